// File: rtl/en8_pkg.sv
// Shared constants and types for the 8-to-3 priority encoder block.
package en8_pkg;
  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  typedef logic [OUT_W-1:0] code_t;
endpackage

// File: rtl/en8_prio.sv
// Purely combinational priority encoder: highest set bit wins, plus any/onehot flags.
module en8_prio
  import en8_pkg::*;
(
  input  logic [IN_W-1:0] d_in,
  output code_t           d_out,
  output logic            any,
  output logic            onehot
);

  always_comb begin
    d_out = '0;
    // Ascending scan so the highest set bit is the last to assign.
    for (int i = 0; i < IN_W; i++) begin
      if (d_in[i]) d_out = code_t'(i);
    end
  end

  assign any    = |d_in;
  assign onehot = any && ((d_in & (d_in - IN_W'(1))) == '0);

endmodule

// File: rtl/en8.sv
// Priority encoder with registered copies, multi-hot sticky error and a saturating valid counter.
module en8
  import en8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  d_in,
  output code_t            d_out,
  output logic             any,
  output logic             onehot,
  output code_t            d_out_q,
  output logic             valid_q,
  output logic             multi_q,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cnt
);

  logic multi;

  en8_prio u_prio (
    .d_in   (d_in),
    .d_out  (d_out),
    .any    (any),
    .onehot (onehot)
  );

  // Two or more bits set: non-zero but not a single bit.
  assign multi = any && !onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q    <= '0;
      valid_q    <= 1'b0;
      multi_q    <= 1'b0;
      err_sticky <= 1'b0;
      cnt        <= '0;
    end else begin
      d_out_q <= d_out;
      valid_q <= any;
      multi_q <= multi;
      if (multi) err_sticky <= 1'b1;
      if (any && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_en8.sv
// Directed bench for en8: combinational checks per step, registered outputs via an expected queue.
module tb_en8;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d_in = 8'h00;

  logic [2:0]  d_out, d_out_q, s_d_out, s_d_out_q;
  logic        any, onehot, valid_q, multi_q, err_sticky;
  logic        s_any, s_onehot, s_valid_q, s_multi_q, s_err_sticky;
  logic [15:0] cnt;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  // Expected registered state: {d_out_q, valid_q, multi_q, err_sticky, cnt16, cnt4}
  logic [25:0] exp_q[$];

  logic [2:0]  m_dq;
  logic        m_vq, m_mq, m_err;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;

  // clock / reset block
  always #5 clk = ~clk;

  en8 #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .d_in(d_in),
    .d_out(d_out), .any(any), .onehot(onehot),
    .d_out_q(d_out_q), .valid_q(valid_q), .multi_q(multi_q),
    .err_sticky(err_sticky), .cnt(cnt)
  );

  en8 #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .d_in(d_in),
    .d_out(s_d_out), .any(s_any), .onehot(s_onehot),
    .d_out_q(s_d_out_q), .valid_q(s_valid_q), .multi_q(s_multi_q),
    .err_sticky(s_err_sticky), .cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clocked step: drive at negedge, check comb, push expectation, check registers after edge.
  task automatic step(input logic [7:0] d, input logic r);
    logic [2:0] e_idx;
    int         ones;
    logic [25:0] e;
    @(negedge clk);
    d_in = d;
    rst  = r;
    e_idx = 3'd0;
    ones  = 0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        e_idx = 3'(i);
        ones++;
      end
    end
    #1;
    chk("d_out",    {29'd0, d_out},    {29'd0, e_idx});
    chk("any",      {31'd0, any},      {31'd0, ones != 0});
    chk("onehot",   {31'd0, onehot},   {31'd0, ones == 1});
    chk("s_d_out",  {29'd0, s_d_out},  {29'd0, e_idx});
    if (r) begin
      m_dq = 3'd0; m_vq = 1'b0; m_mq = 1'b0; m_err = 1'b0; m_cnt = 16'd0; m_cnt4 = 4'd0;
    end else begin
      m_dq = e_idx;
      m_vq = (ones != 0);
      m_mq = (ones >= 2);
      m_err = m_err | (ones >= 2);
      if (ones != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (ones != 0 && m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    exp_q.push_back({m_dq, m_vq, m_mq, m_err, m_cnt, m_cnt4});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("d_out_q",    {29'd0, d_out_q},    {29'd0, e[25:23]});
      chk("valid_q",    {31'd0, valid_q},    {31'd0, e[22]});
      chk("multi_q",    {31'd0, multi_q},    {31'd0, e[21]});
      chk("err_sticky", {31'd0, err_sticky}, {31'd0, e[20]});
      chk("cnt",        {16'd0, cnt},        {16'd0, e[19:4]});
      chk("s_cnt",      {28'd0, s_cnt},      {28'd0, e[3:0]});
      chk("s_d_out_q",  {29'd0, s_d_out_q},  {29'd0, e[25:23]});
      chk("s_err",      {31'd0, s_err_sticky}, {31'd0, e[20]});
    end
  endtask

  initial begin
    m_dq = 3'd0; m_vq = 1'b0; m_mq = 1'b0; m_err = 1'b0; m_cnt = 16'd0; m_cnt4 = 4'd0;
    // reset, then a cycle of zero input: counter must not move
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    // one-hot walk over bits 0..6
    for (int i = 0; i < 7; i++) step(8'h01 << i, 1'b0);
    step(8'h00, 1'b0);
    // multi-hot sets sticky error, then a one-hot leaves it set
    step(8'b1010_0000, 1'b0);
    step(8'h01, 1'b0);
    chk("cnt_before_rst", {16'd0, cnt}, 32'd9);
    // mid-run reset while sticky/count non-zero; comb path keeps tracking
    step(8'h80, 1'b1);
    step(8'h80, 1'b0);
    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(8'h10, 1'b0);
    chk("s_cnt_sat", {28'd0, s_cnt}, 32'd15);
    // random mix
    for (int i = 0; i < 30; i++) step(8'($urandom_range(0, 255)), 1'b0);
    // reset wins over saturation and sticky error
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b1);
    step(8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
